// File: rtl/counter_5b_pkg.sv
// Shared constants for the multdiv iteration counter.
package counter_5b_pkg;

  localparam int COUNT_W = 5;

endpackage : counter_5b_pkg

// File: rtl/counter_5b_dffe_bit.sv
// Single-bit D flop with load enable and synchronous clear; powers up at 0.
module dffe_bit (
  input  logic clock,
  input  logic clr,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q = 1'b0;

  // Clear has priority over the load enable.
  always_ff @(posedge clock) begin
    if (clr) begin
      r_q <= 1'b0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : dffe_bit

// File: rtl/counter_5b.sv
// 5-bit ripple-carry up-counter with enable and synchronous clear, wrapping mod 32.
module counter_5b
  import counter_5b_pkg::*;
(
  input  logic               clock,
  input  logic               clr,
  input  logic               enable,
  output logic [COUNT_W-1:0] out
);

  logic [COUNT_W-1:0] w_count;
  logic [COUNT_W-1:0] w_carry;
  logic [COUNT_W-1:0] w_next;

  // Bit i toggles when enable is high and every lower bit is already 1.
  assign w_carry[0] = enable;
  for (genvar i = 1; i < COUNT_W; i++) begin : g_carry
    assign w_carry[i] = w_carry[i-1] & w_count[i-1];
  end

  assign w_next = w_count ^ w_carry;

  for (genvar i = 0; i < COUNT_W; i++) begin : g_bit
    dffe_bit u_bit (
      .clock (clock),
      .clr   (clr),
      .i_en  (1'b1),
      .i_d   (w_next[i]),
      .o_q   (w_count[i])
    );
  end

  assign out = w_count;

endmodule : counter_5b

// File: tb/tb_counter_5b.sv
// Self-checking bench for counter_5b: directed test-plan steps, then random clr/enable traffic.
module tb_counter_5b;

  logic       clock = 1'b0;
  logic       clr   = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] out;

  int testsRun  = 0;
  int testsFail = 0;
  int model     = 0;

  counter_5b dut (
    .clock  (clock),
    .clr    (clr),
    .enable (enable),
    .out    (out)
  );

  always #5 clock = ~clock;

  // Drive one edge's worth of inputs, advance past the edge and update the reference count.
  task automatic applyStimulus(input logic c, input logic e);
    clr    = c;
    enable = e;
    @(posedge clock);
    #1;
    if (c)      model = 0;
    else if (e) model = (model + 1) % 32;
  endtask

  task automatic checkOutput(input string tag, input int expected);
    logic [4:0] exp5;
    exp5 = expected[4:0];
    testsRun++;
    assert (out === exp5)
      else begin
        testsFail++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, out, exp5);
      end
  endtask

  initial begin
    #1;
    checkOutput("power_up", 0);

    // Free-run from power-up; after edge k the count reads k.
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("free_run", k);
    end

    // Raise clr mid-cycle: no effect until the next edge.
    #2;
    clr = 1'b1;
    #1;
    checkOutput("clr_mid_cycle", 16);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("clr_held", 0);
    end

    // Wrap: 32 enabled edges from 0 return to 0, 33rd gives 1.
    for (int k = 1; k <= 33; k++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("wrap", k % 32);
      if (k == 32) checkOutput("wrap_model", model);
    end

    // Hold at 7 with enable low, then resume.
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1);
    checkOutput("reach_7", 7);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("hold", 7);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("resume", 8);

    // Clear priority with enable low at 20, then release.
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b1);
    checkOutput("reach_20", 20);
    applyStimulus(1'b1, 1'b0);
    checkOutput("clr_en_low", 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("release_1", 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("release_2", 2);

    // Random traffic against the reference count.
    for (int k = 0; k < 300; k++) begin
      applyStimulus(($urandom_range(0, 15) == 0), $urandom_range(0, 3) != 0);
      checkOutput("random", model);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule : tb_counter_5b

// File: doc/counter_5b.md
# counter_5b

Fixed-width 5-bit synchronous up-counter used as the iteration counter of the multiply/divide unit, which steps one count per algorithm cycle and detects completion from the count value. It increments once per clock while enabled and wraps modulo 32. A synchronous clear returns it to zero. The output is the registered count itself; there is no combinational path from inputs to output.

## Interface
- Parameters: none; width is fixed at 5 bits.
- Timing/reset: one clock; reset is synchronous and active-high.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `clr`  in  1  synchronous active-high reset/clear; forces count to 0 at the next rising edge.
- `enable`  in  1  count enable; when high and `clr` low, the count increments at the rising edge.
- `out`  out  5  current count, unsigned, driven directly from the state flops.

## Operation
- State is a 5-bit unsigned register `count`, and `out` = `count`.
- Per rising edge, in priority order:
  - `clr`=1: `count` <- 0, regardless of `enable`.
  - `clr`=0 and `enable`=1: `count` <- (`count` + 1) mod 32.
  - `clr`=0 and `enable`=0: `count` holds.
- Wrap-around: 31 followed by an enabled edge gives 0, with no carry-out or flag.
- Power-up value: state flops initialise to 0, so the count is 0 before any `clr`. A bench may run from time 0 without a reset pulse.
- `clr` and `enable` asserted together: `clr` wins and the result is 0.
- `clr` held high: `out` stays 0 every cycle.
- Increment logic is ripple-carry per bit:
  - Bit i toggles when `enable` is high and bits 0..i-1 are all 1.
  - Bit 0 toggles on every enabled edge.

## Timing
- Latency is 1 cycle: an input change is visible on `out` just after the next rising edge.
- `out` is stable for the whole cycle and changes only after a rising edge.
- A sample taken at a rising edge sees the pre-edge value. With `enable` high from power-up, samples at edges 1, 2, 3, … read 0, 1, 2, …
- `clr` asserted mid-cycle takes effect only at the following edge. The clear is not asynchronous.
- No multi-cycle paths. Critical path is the 5-bit carry chain into bit 4's flop input.

## Structure
- No shared package is needed. If the codebase keeps width constants centrally, a single constant COUNT_W = 5 may go in the common multdiv package.
- One natural sub-module, `dffe_bit`:
  - Single-bit D flop with enable and synchronous clear; initial value 0.
  - Instantiated 5 times.
- Top level holds:
  - the AND-chain carry terms (`enable` & q0 & … & q(i-1));
  - per-bit XOR toggle logic;
  - flop enable tied high, or toggle-gated. Either choice is acceptable if behaviour matches.

## Test plan
- Free-run from power-up: `enable`=1, `clr`=0 for 16 edges. Required edge-sampled sequence 0,1,…,15; `out`=16 after the 16th edge.
- Clear during counting: after 16 counts, raise `clr` between edges. Required: `out`=0 after the next edge, and stays 0 for 16 further edges while `clr`=1 and `enable`=1.
- Wrap: count from 0 for 32 enabled edges. Required: `out` goes 30, 31, then 0, then 1 on the 33rd edge.
- Hold: reach 7, drop `enable` for 5 edges. Required: `out`=7 throughout; resumes 8 on the first edge after `enable` returns high.
- Clear priority and release: `clr`=1 with `enable`=0 at `out`=20. Required: 0 after one edge. Then release `clr` with `enable`=1. Required: 1 after the first edge and 2 after the second.
